// File: rtl/joy_pkg.sv
// Shared constants for the DB9 joystick conditioner.
// Bit map follows the Kempston order; all lines are active-low.
package joy_pkg;

  localparam int JOY_W     = 5;
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE  = 4;

  localparam logic [JOY_W-1:0] JOY_RELEASED = 5'b11111;

endpackage

// File: rtl/joy_debounce_bit.sv
// One pad line: two-flop synchroniser, hold counter, stable flop.
// The change pulse is registered alongside the stable flop.
module joy_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 28000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // bring the asynchronous pad into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // accept a new level only after it has held for the full count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable  <= 1'b1;
      cnt     <= '0;
      changed <= 1'b0;
    end else if (sync2 == stable) begin
      cnt     <= '0;
      changed <= 1'b0;
    end else if (cnt == LAST) begin
      stable  <= sync2;
      cnt     <= '0;
      changed <= 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
      changed <= 1'b0;
    end
  end

endmodule

// File: rtl/joy_conditioner.sv
// DB9 joystick conditioner: sync + debounce five active-low lines.
// Optional autofire on the fire line when JOY_AUTOFIRE_EN is defined.
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 28000,
  parameter int AUTOFIRE_HALF   = 1400000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [JOY_W-1:0] joy_raw,
  input  logic             autofire_enable,
  output logic [JOY_W-1:0] joy_out,
  output logic             joy_changed
);

  logic [JOY_W-1:0] stable;
  logic [JOY_W-1:0] pulse;

  for (genvar i = 0; i < JOY_W; i++) begin : g_bit
    joy_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .raw    (joy_raw[i]),
      .stable (stable[i]),
      .changed(pulse[i])
    );
  end

  assign joy_changed = |pulse;

`ifdef JOY_AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_HALF);
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_HALF - 1);

  logic          af_on;
  logic          phase;
  logic [AW-1:0] af_cnt;

  assign af_on = ~stable[JOY_FIRE] & autofire_enable;

  // free-running half-period timer, parked at pressed while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_cnt <= '0;
      phase  <= 1'b0;
    end else if (!af_on) begin
      af_cnt <= '0;
      phase  <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt <= '0;
      phase  <= ~phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  // fire follows the autofire phase while held with autofire on
  always_comb begin
    joy_out = stable;
    if (af_on) joy_out[JOY_FIRE] = phase;
  end
`else
  localparam int unused_af_half = AUTOFIRE_HALF;
  logic unused_af_enable;

  assign unused_af_enable = autofire_enable;

  // without autofire the stable lines are presented directly
  always_comb begin
    joy_out = stable;
  end
`endif

endmodule

// File: tb/tb_joy_conditioner.sv
// Bench for joy_conditioner: table vectors, corner sequences,
// and random stimulus against a run-length reference model.
module tb_joy_conditioner;

  import joy_pkg::*;

  localparam int D = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] joy_raw;
  logic       autofire_enable;
  logic [4:0] joy_out;
  logic       joy_changed;

  always #5 clk = ~clk;

  joy_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .AUTOFIRE_HALF  (H)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .joy_raw        (joy_raw),
    .autofire_enable(autofire_enable),
    .joy_out        (joy_out),
    .joy_changed    (joy_changed)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_model = 0;

  // reference model: raw delayed two edges, then a level is accepted
  // once it has disagreed with the stable value for D edges in a row
  logic [4:0] m_d1, m_d2, m_st;
  int         m_run[5];
  logic       m_chg;
  int         m_af;

  typedef struct {
    logic [4:0] raw;
    int         n;
    logic [4:0] out;
    logic       chg;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [4:0] act,
                     input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_d1 = '1;
    m_d2 = '1;
    m_st = '1;
    foreach (m_run[b]) m_run[b] = 0;
    m_chg = 1'b0;
    m_af  = 0;
  endtask

  task automatic m_edge();
    bit af_pre;
    if (rst) begin
      m_reset();
    end else begin
      af_pre = !m_st[JOY_FIRE] && autofire_enable;
      m_chg = 1'b0;
      for (int b = 0; b < 5; b++) begin
        if (m_d2[b] != m_st[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_st[b]  = m_d2[b];
            m_run[b] = 0;
            m_chg    = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = joy_raw;
      m_af = af_pre ? m_af + 1 : 0;
    end
  endtask

  function automatic logic [4:0] m_out();
    logic [4:0] o;
    o = m_st;
`ifdef JOY_AUTOFIRE_EN
    if (!m_st[JOY_FIRE] && autofire_enable)
      o[JOY_FIRE] = ((m_af / H) % 2) != 0;
`endif
    return o;
  endfunction

  task automatic cyc();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    if (chk_model) begin
      chk("model_out", joy_out, m_out());
      chk("model_chg", {4'b0, joy_changed}, {4'b0, m_chg});
    end
  endtask

  initial begin
    logic [4:0] e;
    rst = 1'b1;
    joy_raw = 5'b00000;
    autofire_enable = 1'b0;
    m_reset();
    #1;
    chk("rst_out", joy_out, 5'b11111);
    chk("rst_chg", {4'b0, joy_changed}, 5'b0);
    repeat (2) begin
      cyc();
      chk("rst_hold_out", joy_out, 5'b11111);
      chk("rst_hold_chg", {4'b0, joy_changed}, 5'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      e = (i == 10) ? 5'b00000 : 5'b11111;
      chk("post_rst_out", joy_out, e);
      chk("post_rst_chg", {4'b0, joy_changed}, {4'b0, i == 10});
    end

    tbl.push_back('{5'b11111,  9, 5'b00000, 1'b0});
    tbl.push_back('{5'b11111,  1, 5'b11111, 1'b1});
    tbl.push_back('{5'b11111,  1, 5'b11111, 1'b0});
    tbl.push_back('{5'b10111,  9, 5'b11111, 1'b0});
    tbl.push_back('{5'b10111,  1, 5'b10111, 1'b1});
    tbl.push_back('{5'b10111,  1, 5'b10111, 1'b0});
    tbl.push_back('{5'b11111, 10, 5'b11111, 1'b1});
    tbl.push_back('{5'b11111,  3, 5'b11111, 1'b0});
    tbl.push_back('{5'b01100,  9, 5'b11111, 1'b0});
    tbl.push_back('{5'b01100,  1, 5'b01100, 1'b1});
    tbl.push_back('{5'b01100,  1, 5'b01100, 1'b0});
    tbl.push_back('{5'b11111, 10, 5'b11111, 1'b1});
    tbl.push_back('{5'b11110,  7, 5'b11111, 1'b0});
    tbl.push_back('{5'b11111, 20, 5'b11111, 1'b0});
    foreach (tbl[i]) begin
      joy_raw = tbl[i].raw;
      repeat (tbl[i].n) cyc();
      chk($sformatf("tbl%0d_out", i), joy_out, tbl[i].out);
      chk($sformatf("tbl%0d_chg", i), {4'b0, joy_changed},
          {4'b0, tbl[i].chg});
    end

    for (int s = 0; s < 10; s++) begin
      joy_raw = {4'b1111, 1'(s % 2)};
      repeat (3) begin
        cyc();
        chk("bounce_out", joy_out, 5'b11111);
      end
    end
    joy_raw = 5'b11110;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      e = (i == 10) ? 5'b11110 : 5'b11111;
      chk("bounce_settle", joy_out, e);
    end
    chk("bounce_chg", {4'b0, joy_changed}, 5'b00001);

    joy_raw = 5'b11111;
    repeat (10) cyc();
    chk("rel0", joy_out, 5'b11111);
    joy_raw = 5'b11101;
    repeat (6) cyc();
    rst = 1'b1;
    #1;
    chk("midrst_out", joy_out, 5'b11111);
    repeat (2) begin
      cyc();
      chk("midrst_hold", joy_out, 5'b11111);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      e = (i == 10) ? 5'b11101 : 5'b11111;
      chk("midrst_after", joy_out, e);
    end

    joy_raw = 5'b11111;
    repeat (10) cyc();
    autofire_enable = 1'b1;
    joy_raw = 5'b01111;
    repeat (10) cyc();
    chk("fire_acc", joy_out, 5'b01111);
    chk("fire_chg", {4'b0, joy_changed}, 5'b1);
`ifdef JOY_AUTOFIRE_EN
    for (int t = 1; t <= 12; t++) begin
      cyc();
      chk("af_held", {4'b0, joy_out[4]}, {4'b0, 1'((t / H) % 2)});
    end
    joy_raw = 5'b11111;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      e = (i == 10) ? 5'b1 : {4'b0, 1'(((12 + i) / H) % 2)};
      chk("af_release", {4'b0, joy_out[4]}, e);
      chk("af_chg", {4'b0, joy_changed}, {4'b0, i == 10});
    end
`else
    for (int t = 1; t <= 12; t++) begin
      cyc();
      chk("fire_held", joy_out, 5'b01111);
      chk("fire_held_chg", {4'b0, joy_changed}, 5'b0);
    end
    joy_raw = 5'b11111;
    repeat (10) cyc();
    chk("fire_rel", joy_out, 5'b11111);
`endif

    chk_model = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0)
        joy_raw[$urandom_range(0, 4)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0)
        autofire_enable = ~autofire_enable;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        m_reset();
        #1;
        chk("rnd_rst", joy_out, 5'b11111);
        repeat (2) cyc();
        rst = 1'b0;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/joy_conditioner.md
Name: joy_conditioner

Overview:
- Sits between the raw DB9 joystick pins and the `zxuno` core's `joyup`/`joydown`/`joyleft`/`joyright`/`joyfire` inputs, in the `sysclk` domain.
- Synchronises the five asynchronous, active-low pad lines and debounces each one independently.
- Presents clean, glitch-free active-low lines in Kempston bit order, plus a one-cycle change strobe.
- Optionally adds hardware autofire on the fire line.

Parameters:
- DEBOUNCE_CYCLES, 28000, clk cycles a raw level must hold before it is accepted (1 ms at 28 MHz); legal range 2..2^20.
- AUTOFIRE_HALF, 1400000, clk cycles per autofire half-period (10 Hz at 28 MHz); used only with JOY_AUTOFIRE_EN.

Ports:
- clk  in  1  system clock (28 MHz `sysclk`)
- rst  in  1  asynchronous reset, active-high
- joy_raw  in  5  raw pad lines, active-low, asynchronous; bit map per package: 0=right, 1=left, 2=down, 3=up, 4=fire
- autofire_enable  in  1  autofire request; ignored unless JOY_AUTOFIRE_EN is defined
- joy_out  out  5  debounced lines, active-low, same bit map
- joy_changed  out  1  one-cycle pulse when any debounced bit changes

Behaviour:
- Reset: async, active-high, on `clk` domain.
  - Synchroniser flops, stable bits and `joy_out` reset to 5'b11111 (all released).
  - Counters reset to 0; `joy_changed` resets to 0.
  - Release of rst needs no special sequencing.
- Synchroniser: two flops per bit, so `sync2` follows `joy_raw` after 2 clk edges.
- Debounce, per bit, with a counter of width $clog2(DEBOUNCE_CYCLES):
  - sync2 == stable → counter <= 0.
  - sync2 != stable and counter != DEBOUNCE_CYCLES-1 → counter++.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1 → stable <= sync2, counter <= 0.
- Latency: a raw level change at edge k, held steady, appears on `stable` (and `joy_out`) at edge k+2+DEBOUNCE_CYCLES.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES clk never reaches `joy_out`. Any bounce back to the stable value restarts that bit's count from 0.
- Bit independence: bits are fully independent. Simultaneous changes on several bits are accepted in the same cycle if their counts expire together.
- `joy_changed`: registered. It is 1 for exactly one cycle, coincident with the edge where any `joy_out` bit changes, and 0 otherwise.
  - It is not asserted for autofire toggles.
- `joy_out`: registered; equals `stable` except fire when autofire is active (see Optional Feature).
- Opposite directions: up and down (or left and right) both pressed are passed through unmodified. No SOCD cleaning.
- Reset mid-count: all counters clear, outputs return to released, and any in-flight change is discarded.

Optional Feature:
- Macro: JOY_AUTOFIRE_EN.
- Defined:
  - A phase counter of width $clog2(AUTOFIRE_HALF) plus a phase flop are added.
  - While stable[4]==0 (fire held) and autofire_enable==1, `joy_out[4]` = phase.
    - Phase starts at 0 (pressed) on the cycle fire becomes held.
    - Phase inverts every AUTOFIRE_HALF cycles.
  - On fire release, or when autofire_enable is 0: phase and counter reset (phase=0, count=0) and `joy_out[4]` = stable[4].
  - autofire_enable is sampled directly and must be synchronous to `clk`.
- Undefined:
  - autofire_enable is unused.
  - `joy_out[4]` = stable[4].
  - No autofire logic is synthesised.

Decomposition:
- Package `joy_pkg`:
  - Bit-index constants JOY_RIGHT=0, JOY_LEFT=1, JOY_DOWN=2, JOY_UP=3, JOY_FIRE=4.
  - JOY_W=5 and JOY_RELEASED=5'b11111.
- Sub-module `joy_debounce_bit`: one bit holding synchroniser, counter and stable flop, parameter DEBOUNCE_CYCLES, outputs stable and a change pulse.
- Top instantiates `joy_debounce_bit` five times via generate, ORs the change pulses, and adds the autofire logic.

Test Plan (sim with DEBOUNCE_CYCLES=8, AUTOFIRE_HALF=4):
- Reset: rst=1 with joy_raw=5'b00000 → joy_out=5'b11111, joy_changed=0 throughout reset and for the first 9 cycles after release. joy_out=5'b00000 at edge 10 after release, with joy_changed=1 for that single cycle.
- Clean press: joy_raw[3] 1→0 at edge k, held → joy_out=5'b10111 exactly at edge k+10, joy_changed=1 for one cycle. No change at edge k+9.
- Bounce: joy_raw[0] toggles 0/1 every 3 cycles for 30 cycles, then holds 0 → joy_out[0] stays 1 until 10 edges after the final transition, then goes to 0.
- Simultaneous: joy_raw 5'b11111→5'b01100 at the same edge → joy_out=5'b01100 at a single edge, exactly one joy_changed pulse.
- Reset mid-count: press bit 1, assert rst at edge k+6 for 2 cycles, keep raw pressed → joy_out[1]=1 during reset. joy_out[1]=0 at edge 10 after rst release.
- Autofire (JOY_AUTOFIRE_EN, autofire_enable=1): hold fire → joy_out[4] goes 0 at acceptance, then toggles every 4 cycles (0,1,0,…). Release fire → joy_out[4]=1 at release acceptance. With the macro undefined, joy_out[4] stays 0 while held.
